fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have clk, input, 1: single rising-edge clock for all state.
REQ-002 SHALL have rst_n, input, 1: reset, asynchronous assert, active-low; all state clears while low.
REQ-003 SHALL have imem_req_valid, output, 1: instruction-memory read request valid.
REQ-004 SHALL have imem_req_addr, output, 16: byte address of the requested instruction word.
REQ-005 SHALL have imem_req_ready, input, 1: memory accepts the request this cycle.
REQ-006 SHALL have imem_rsp_valid, input, 1: returned instruction word valid; in-order, any latency of 1 or more cycles.
REQ-007 SHALL have imem_rsp_data, input, 16: returned instruction word.
REQ-008 SHALL have instr_valid, output, 1: instruction offered to decode.
REQ-009 SHALL have instruction, output, 16: instruction word to decode.
REQ-010 SHALL have pc_plus2, output, 16: address of the offered instruction plus 2, used for JAL/JALR link.
REQ-011 SHALL have instr_ready, input, 1: decode consumes the offered instruction this cycle.
REQ-012 SHALL have redirect, input, 1: taken branch/jump from a later stage.
REQ-013 SHALL have redirect_pc, input, 16: target address for redirect.
REQ-014 SHALL have halted, output, 1: HALT has been consumed and fetch is stopped.
REQ-015 SHALL have err, output, 1: sticky misaligned-redirect flag.

Function
REQ-016 SHALL use a 2-entry instruction buffer holding {word, pc_plus2}; instr_valid = buffer not empty; instruction and pc_plus2 come from the head entry.
REQ-017 SHALL keep at most one memory request outstanding.
REQ-018 SHALL assert imem_req_valid in FSM state RUN only when (buffer count + outstanding) < 2.
REQ-019 SHALL advance fetch PC by 2 on the request handshake (valid & ready); PC wraps 0xFFFE -> 0x0000.
REQ-020 SHALL push a response into the buffer in its arrival cycle; instr_valid rises the next cycle (1-cycle response-to-decode latency).
REQ-021 SHALL allow a same-cycle push and pop; the count is unchanged.
REQ-022 SHALL use FSM states RUN, DRAIN and HALTED: RUN -> DRAIN when a word with opcode[15:11]=00000 (HALT) is pushed; DRAIN issues no requests; DRAIN -> HALTED when decode consumes the HALT; HALTED is exited only by reset.
REQ-023 SHALL, on redirect in RUN or DRAIN: flush the buffer, mark any outstanding response squashed (discard it on arrival), load PC <= {redirect_pc[15:1],0}, and go to RUN, all in that cycle; no request issues in the redirect cycle.
REQ-024 SHALL, if redirect_pc[0]=1 on redirect, set err (sticky until reset).
REQ-025 SHALL give redirect priority over a simultaneous pop, push or HALT consume; a HALT consumed in the redirect cycle does not set halted.
REQ-026 SHALL ignore redirect in HALTED; instr_valid=0 and imem_req_valid=0 there.

Reset
REQ-027 SHALL, while rst_n is low, force: PC=0x0000, buffer empty, outstanding=0, squash=0, state=RUN, halted=0, err=0, all outputs 0.
REQ-028 SHALL issue the first request (addr 0x0000) in the first clock after rst_n deasserts; asserting reset mid-request drops that request and any later response.

Configuration
REQ-029 SHALL, with FETCH_PERF_CNT_EN defined, add output perf_stall_cnt[15:0]: a saturating count of cycles with state != HALTED and instr_valid=0, reset to 0.
REQ-030 SHALL, without FETCH_PERF_CNT_EN, have no such port and no counter logic.

Structure
REQ-031 SHALL take OP_HALT (5'b00000), the reset PC (16'h0000) and the buffer depth (2) from a shared package also used by decode.
REQ-032 SHALL implement the buffer as sub-module fetch_fifo (2-entry, push/pop/flush, count output).

Verification
REQ-033 SHALL test: reset release, memory 1-cycle latency, instr_ready=1 -> requests to 0x0000, 0x0002, 0x0004; instr_valid first high 2 cycles after the first request; pc_plus2 = 0x0002, 0x0004.
REQ-034 SHALL test: instr_ready=0 for 5 cycles -> exactly 2 words buffered, imem_req_valid=0, no loss or duplication after resume.
REQ-035 SHALL test: redirect to 0x0040 while a response is outstanding -> stale word discarded, next instruction has pc_plus2=0x0042, err=0.
REQ-036 SHALL test: HALT word at 0x0006 -> no further requests; halted=1 the cycle after it is consumed; later redirect ignored.
REQ-037 SHALL test: redirect_pc=0x0013 -> fetch from 0x0012, err=1 until reset; PC at 0xFFFE wraps to next request 0x0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: HALT opcode, reset PC, buffer depth and
// the fetch FSM state encoding.
package fetch_pkg;

  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam int          BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc_plus2;
  } buf_entry_t;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding {word, pc_plus2}; flush empties it and
// wins over a same-cycle push or pop.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [15:0] push_word,
  input  logic [15:0] push_pc_plus2,
  input  logic        pop,
  input  logic        flush,
  output logic [15:0] head_word,
  output logic [15:0] head_pc_plus2,
  output logic [1:0]  count
);

  buf_entry_t entry_reg [BUF_DEPTH];
  buf_entry_t head;
  logic       rd_ptr_reg;
  logic       wr_ptr_reg;
  logic [1:0] count_reg;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count_reg != 2'd0) && !flush;
  assign do_push = push && !flush && ((count_reg != 2'(BUF_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) entry_reg[i] <= '0;
    end else if (do_push) begin
      entry_reg[wr_ptr_reg] <= '{word: push_word, pc_plus2: push_pc_plus2};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head          = entry_reg[rd_ptr_reg];
  assign head_word     = head.word;
  assign head_pc_plus2 = head.pc_plus2;
  assign count         = count_reg;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding memory request, 2-entry buffer to decode,
// redirect/flush with response squash, HALT drain. FETCH_PERF_CNT_EN adds a stall counter.
module fetch
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [15:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [15:0] instruction,
  output logic [15:0] pc_plus2,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic        err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_stall_cnt
`endif
);

  fetch_state_t state_reg, state_next;
  logic [15:0]  pc_reg;
  logic [15:0]  outst_pc2_reg;
  logic         outst_reg;
  logic         squash_reg;
  logic         err_reg;

  logic         redir_eff;
  logic         rsp_hit;
  logic         push;
  logic         push_halt;
  logic         pop;
  logic         halt_consume;
  logic         req_fire;
  logic [1:0]   fifo_count;
  logic [1:0]   occupancy;

  assign redir_eff = redirect && (state_reg != HALTED);
  assign rsp_hit   = imem_rsp_valid && outst_reg;
  assign push      = rsp_hit && !squash_reg && !redir_eff;
  assign push_halt = push && is_halt(imem_rsp_data);
  assign occupancy = fifo_count + {1'b0, outst_reg};

  // A new request may share the cycle in which the outstanding response lands;
  // nothing is fetched behind a HALT word.
  assign imem_req_valid = rst_n && (state_reg == RUN) && !redir_eff && !push_halt &&
                          (occupancy < 2'(BUF_DEPTH)) && (!outst_reg || rsp_hit);
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid  = (state_reg != HALTED) && (fifo_count != 2'd0);
  assign pop          = instr_valid && instr_ready && !redir_eff;
  assign halt_consume = (state_reg == DRAIN) && pop && is_halt(instruction);
  assign halted       = (state_reg == HALTED);
  assign err          = err_reg;

  fetch_fifo u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (push),
    .push_word     (imem_rsp_data),
    .push_pc_plus2 (outst_pc2_reg),
    .pop           (pop),
    .flush         (redir_eff),
    .head_word     (instruction),
    .head_pc_plus2 (pc_plus2),
    .count         (fifo_count)
  );

  always_comb begin
    state_next = state_reg;
    if (redir_eff) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN:     if (push_halt)    state_next = DRAIN;
        DRAIN:   if (halt_consume) state_next = HALTED;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      pc_reg        <= RESET_PC;
      outst_pc2_reg <= 16'h0000;
      outst_reg     <= 1'b0;
      squash_reg    <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (redir_eff) begin
        pc_reg     <= {redirect_pc[15:1], 1'b0};
        squash_reg <= outst_reg && !rsp_hit;
        if (redirect_pc[0]) err_reg <= 1'b1;
      end else if (req_fire) begin
        pc_reg <= pc_reg + 16'd2;
      end
      if (!redir_eff && rsp_hit) squash_reg <= 1'b0;
      if (req_fire) begin
        outst_reg     <= 1'b1;
        outst_pc2_reg <= pc_reg + 16'd2;
      end else if (rsp_hit) begin
        outst_reg <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_reg <= 16'h0000;
    end else if ((state_reg != HALTED) && !instr_valid && (perf_cnt_reg != 16'hFFFF)) begin
      perf_cnt_reg <= perf_cnt_reg + 16'd1;
    end
  end

  assign perf_stall_cnt = perf_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: in-order memory with random latency/backpressure,
// plus an instruction-stream reference model (sequential PCs, redirects, HALT).
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [15:0] pc_plus2;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;
  logic        err;

  always #5 clk = ~clk;

  fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .pc_plus2       (pc_plus2),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .err            (err)
  );

  typedef struct {
    logic [15:0] data;
    int          due;
  } rsp_t;

  rsp_t        rq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc;
  int          rdy_pct, lat_min, lat_max, dec_pct, redir_pm;
  logic        force_redir;
  logic [15:0] force_pc;
  logic [15:0] halt_addr;
  logic        ghost_valid;
  logic [15:0] ghost_data;

  // reference model of the architecturally visible stream
  logic [15:0] exp_req_addr, exp_dec_pc, last_pc2;
  logic        exp_err, exp_halted, halt_req_seen;
  int          first_req_cyc, first_iv_cyc, n_consumed;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (a == halt_addr) return {5'b00000, a[10:0]};
    w = (a * 16'h9E37) ^ 16'h5A5A;
    if (w[15:11] == 5'b00000) w[15] = 1'b1;
    return w;
  endfunction

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0;
    instr_ready    = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req_valid", imem_req_valid, 0);
    check_val("rst_req_addr", imem_req_addr, 16'h0000);
    check_val("rst_instr_valid", instr_valid, 0);
    check_val("rst_pc_plus2", pc_plus2, 16'h0000);
    check_val("rst_halted", halted, 0);
    check_val("rst_err", err, 0);
    rq.delete();
    exp_req_addr  = 16'h0000;
    exp_dec_pc    = 16'h0000;
    exp_err       = 1'b0;
    exp_halted    = 1'b0;
    halt_req_seen = 1'b0;
    first_req_cyc = -1;
    first_iv_cyc  = -1;
    cyc           = 0;
    rst_n         = 1'b1;
  endtask

  task automatic do_cycle();
    logic        rsp_now, fire, halt_now;
    logic [15:0] w;
    rsp_t        r;
    @(posedge clk);
    #1;
    cyc++;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    rsp_now        = (rq.size() > 0) && (rq[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? rq[0].data : 16'($urandom);
    if (!rsp_now && ghost_valid) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ghost_data;
      ghost_valid    = 1'b0;
    end
    instr_ready = ($urandom_range(99) < dec_pct);
    if (force_redir) begin
      redirect    = 1'b1;
      redirect_pc = force_pc;
      force_redir = 1'b0;
    end else begin
      redirect    = ($urandom_range(999) < redir_pm);
      redirect_pc = 16'($urandom) & 16'hFFFE;
    end
    @(negedge clk);
    halt_now = 1'b0;
    check_val("err", err, exp_err);
    check_val("halted", halted, exp_halted);
    if (exp_halted) begin
      check_val("halted_instr_valid", instr_valid, 0);
      check_val("halted_req_valid", imem_req_valid, 0);
    end
    if (redirect && !exp_halted) check_val("redirect_no_req", imem_req_valid, 0);
    if (halt_req_seen) check_val("req_after_halt", imem_req_valid, 0);
    fire = imem_req_valid && imem_req_ready;
    if (fire) begin
      check_val("req_addr", imem_req_addr, exp_req_addr);
      check_val("one_outstanding", rq.size() - int'(rsp_now), 0);
      if (first_req_cyc < 0) first_req_cyc = cyc;
      w = mem_word(imem_req_addr);
      if (w[15:11] == 5'b00000) halt_req_seen = 1'b1;
      r.data = w;
      r.due  = cyc + int'($urandom_range(lat_max, lat_min));
      rq.push_back(r);
      exp_req_addr = exp_req_addr + 16'd2;
    end
    if (rsp_now) void'(rq.pop_front());
    if (instr_valid && first_iv_cyc < 0) first_iv_cyc = cyc;
    if (instr_valid && instr_ready && !(redirect && !exp_halted)) begin
      w = mem_word(exp_dec_pc);
      check_val("instruction", instruction, w);
      check_val("pc_plus2", pc_plus2, 16'(exp_dec_pc + 16'd2));
      last_pc2 = pc_plus2;
      n_consumed++;
      if (w[15:11] == 5'b00000) halt_now = 1'b1;
      exp_dec_pc = exp_dec_pc + 16'd2;
    end
    if (redirect && !exp_halted) begin
      exp_err       = exp_err | redirect_pc[0];
      exp_req_addr  = {redirect_pc[15:1], 1'b0};
      exp_dec_pc    = {redirect_pc[15:1], 1'b0};
      halt_req_seen = 1'b0;
    end else if (halt_now) begin
      exp_halted = 1'b1;
    end
  endtask

  task automatic set_mode(input int rdy, input int lmin, input int lmax, input int dec, input int rpm);
    rdy_pct  = rdy;
    lat_min  = lmin;
    lat_max  = lmax;
    dec_pct  = dec;
    redir_pm = rpm;
  endtask

  task automatic run_until_halted(input string tag, input int budget);
    for (int i = 0; i < budget && !halted; i++) do_cycle();
    check_val(tag, halted, 1);
  endtask

  initial begin
    int n0;
    force_redir = 1'b0;
    force_pc    = 16'h0;
    ghost_valid = 1'b0;
    ghost_data  = 16'h0;
    halt_addr   = 16'h0001;
    n_consumed  = 0;
    last_pc2    = 16'h0;

    // sequential fetch with 1-cycle memory
    do_reset();
    set_mode(100, 1, 1, 100, 0);
    repeat (12) do_cycle();
    check_val("first_req_cycle", first_req_cyc, 1);
    check_val("req_to_valid_latency", first_iv_cyc - first_req_cyc, 2);

    // decode stall: buffer fills to exactly two words, then drains with memory blocked
    set_mode(100, 1, 1, 0, 0);
    repeat (5) do_cycle();
    check_val("stall_req_idle", imem_req_valid, 0);
    set_mode(0, 1, 1, 100, 0);
    n0 = n_consumed;
    repeat (4) do_cycle();
    check_val("stall_buffered_words", n_consumed - n0, 2);
    set_mode(100, 1, 1, 100, 0);
    repeat (6) do_cycle();

    // redirect while a response is in flight
    set_mode(100, 3, 3, 100, 0);
    for (int i = 0; i < 20 && rq.size() == 0; i++) do_cycle();
    check_val("redirect_setup_outstanding", rq.size() > 0, 1);
    force_redir = 1'b1;
    force_pc    = 16'h0040;
    do_cycle();
    set_mode(100, 1, 2, 100, 0);
    n0 = n_consumed;
    for (int i = 0; i < 30 && n_consumed == n0; i++) do_cycle();
    check_val("redirect_first_pc_plus2", last_pc2, 16'h0042);
    check_val("redirect_err_clear", err, 0);

    // random traffic with random even redirects
    set_mode(70, 1, 3, 60, 15);
    repeat (1500) do_cycle();

    // HALT at 0x0006: stop fetching, halted, ignore later redirect
    do_reset();
    halt_addr = 16'h0006;
    set_mode(100, 1, 1, 100, 0);
    run_until_halted("halt_reached", 60);
    repeat (4) do_cycle();
    force_redir = 1'b1;
    force_pc    = 16'h0011;
    repeat (6) do_cycle();
    check_val("halt_redirect_ignored", halted, 1);
    check_val("halt_redirect_no_err", err, 0);

    // HALT under random latency and decode backpressure
    do_reset();
    set_mode(70, 1, 3, 50, 0);
    run_until_halted("halt_reached_random", 300);
    repeat (5) do_cycle();

    // misaligned redirect, then wrap at 0xFFFE
    do_reset();
    halt_addr = 16'h0001;
    set_mode(80, 1, 2, 80, 0);
    repeat (4) do_cycle();
    force_redir = 1'b1;
    force_pc    = 16'h0013;
    repeat (10) do_cycle();
    check_val("misaligned_err", err, 1);
    force_redir = 1'b1;
    force_pc    = 16'hFFFC;
    set_mode(100, 1, 1, 100, 0);
    repeat (12) do_cycle();
    check_val("wrap_req_addr_model", exp_req_addr < 16'h0040, 1);
    check_val("err_sticky", err, 1);

    // reset in the middle of a request: its late response must be dropped
    set_mode(100, 4, 4, 100, 0);
    for (int i = 0; i < 20 && rq.size() == 0; i++) do_cycle();
    check_val("midreset_setup_outstanding", rq.size() > 0, 1);
    if (rq.size() > 0) begin
      ghost_data  = rq[0].data;
      ghost_valid = 1'b1;
    end
    do_reset();
    set_mode(100, 1, 1, 100, 0);
    repeat (12) do_cycle();
    check_val("midreset_err_cleared", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
